data_memory_bytelane: RTL and testbench

Parametrised successor to the single-cycle word data memory. Byte-addressed, little-endian, with byte/half/word loads and stores, sign or zero extension on loads, and an explicit result_valid pulse. A post-reset init sequencer preloads the array without a combinational reset fan-out, and alignment and range errors are flagged. Sits in the MEM stage of the datapath between the ALU address output and the write-back mux.

---
 rtl/data_memory_pkg.sv | 44 ++++
 rtl/data_memory_load_align.sv | 33 +++
 rtl/data_memory_bytelane.sv | 186 ++++++++++++++++++
 tb/tb_data_memory_bytelane.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared encodings and helpers for the byte-lane data memory.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package data_memory_pkg;

  localparam int BYTES_PER_WORD = 4;

  // Access size field as driven by the decode stage
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  // Byte-enable mask for a store of the given size starting at the given lane.
  // Alignment is checked elsewhere, so a half never straddles the word here.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << lane;
      SIZE_HALF: m = 4'b0011 << lane;
      SIZE_WORD: m = 4'b1111;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

  // True when the request violates natural alignment or uses the reserved size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lane[0];
      SIZE_WORD: bad = (lane != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_memory_load_align.sv
// Extracts the addressed byte/half/word from a memory word and sign/zero extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module data_memory_load_align
  import data_memory_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic        sign_b;
  logic        sign_h;

  // Little-endian: move the addressed lane down to bit 0
  assign shifted = word_i >> {lane_i, 3'b000};
  assign sign_b  = ~unsigned_i & shifted[7];
  assign sign_h  = ~unsigned_i & shifted[15];

  // Extend the selected field; word accesses are lane 0 so shifted is the word
  always_comb begin
    data_o = shifted;
    case (size_i)
      SIZE_BYTE: data_o = {{24{sign_b}}, shifted[7:0]};
      SIZE_HALF: data_o = {{16{sign_h}}, shifted[15:0]};
      default:   data_o = shifted;
    endcase
  end

endmodule

// File: rtl/data_memory_bytelane.sv
// MEM-stage byte-addressed data memory with byte/half/word access and post-reset preload.
// Latency: stores land at the request edge; loads return result one edge later with result_valid.
// Backpressure: busy high during preload; requests seen while busy are dropped silently.
module data_memory_bytelane
  import data_memory_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 32,
  parameter bit INIT_MODE = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [1:0]        size,
  input  logic              unsigned_load,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic [31:0]       result,
  output logic              result_valid,
  output logic              busy,
  output logic              misaligned_error,
  output logic              range_error
);

  localparam int                IDX_W      = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * BYTES_PER_WORD);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);

  // Storage: not reset, contents come from the preload sequencer
  logic [31:0] mem_q [DEPTH];

  // Control state
  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;

  // Registered outputs
  logic [31:0] result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic        misaligned_q, misaligned_d;
  logic        range_q, range_d;

  // Request decode
  logic [1:0]       lane;
  logic [IDX_W-1:0] req_idx;
  logic             range_hit;
  logic             mis_hit;
  logic             req_live;
  logic             access_ok;
  logic             do_store;
  logic             do_load;

  // Single write port shared by preload and stores
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_dat;
  logic [31:0]      store_dat;

  logic [31:0] rd_word;
  logic [31:0] load_val;

  assign lane      = address[1:0];
  assign req_idx   = address[IDX_W+1:2];
  assign range_hit = (address >= ADDR_LIMIT);
  assign mis_hit   = is_misaligned(size, lane);
  assign req_live  = (mem_write | mem_read) & ~busy;
  assign access_ok = req_live & ~range_hit & ~mis_hit;
  // Write wins over a simultaneous read; the read is dropped, not deferred
  assign do_store  = access_ok & mem_write;
  assign do_load   = access_ok & mem_read & ~mem_write;

  // FSM state register: reset restarts the preload from word 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  // FSM next state: walk every word once, then serve requests forever
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      IDLE:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // FSM outputs: busy is a decode of the registered state, so it is glitch-free
  always_comb begin
    busy = 1'b1;
    case (state_q)
      INIT:    busy = 1'b1;
      IDLE:    busy = 1'b0;
      default: busy = 1'b1;
    endcase
  end

  // Replicate the store operand so every lane sees its bytes; the mask picks lanes
  always_comb begin
    store_dat = write_data;
    case (size)
      SIZE_BYTE: store_dat = {4{write_data[7:0]}};
      SIZE_HALF: store_dat = {2{write_data[15:0]}};
      default:   store_dat = write_data;
    endcase
  end

  // Write-port mux: the preload owns the array until busy drops
  always_comb begin
    wr_en  = do_store;
    wr_idx = req_idx;
    wr_be  = lane_mask(size, lane);
    wr_dat = store_dat;
    if (busy) begin
      wr_en  = 1'b1;
      wr_idx = init_ptr_q;
      wr_be  = 4'b1111;
      wr_dat = INIT_MODE ? 32'(init_ptr_q) : 32'd0;
    end
  end

  // Byte-lane array write; untouched lanes keep their old contents
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
        end
      end
    end
  end

  assign rd_word = mem_q[req_idx];

  data_memory_load_align u_load_align (
    .word_i     (rd_word),
    .lane_i     (lane),
    .size_i     (size),
    .unsigned_i (unsigned_load),
    .data_o     (load_val)
  );

  // Response next-state: result only moves on a serviced load, pulses last one cycle
  always_comb begin
    result_d       = result_q;
    result_valid_d = do_load;
    misaligned_d   = req_live & mis_hit;
    range_d        = req_live & range_hit;
    if (do_load) begin
      result_d = load_val;
    end
  end

  // Response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
      misaligned_q   <= 1'b0;
      range_q        <= 1'b0;
    end else begin
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      misaligned_q   <= misaligned_d;
      range_q        <= range_d;
    end
  end

  assign result           = result_q;
  assign result_valid     = result_valid_q;
  assign misaligned_error = misaligned_q;
  assign range_error      = range_q;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed bench for data_memory_bytelane with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// A shadow word array tracks stores so the full array can be dumped and compared.
module tb_data_memory_bytelane;

  localparam int DEPTH = 32;

  logic        clock;
  logic        reset;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  size;
  logic        unsigned_load;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;
  logic        misaligned_error;
  logic        range_error;

  int n_total;
  int n_bad;
  int n_busy;
  logic [31:0] mdl [DEPTH];

  data_memory_bytelane #(
    .DEPTH     (DEPTH),
    .ADDR_W    (32),
    .INIT_MODE (1'b1)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .mem_write        (mem_write),
    .mem_read         (mem_read),
    .size             (size),
    .unsigned_load    (unsigned_load),
    .address          (address),
    .write_data       (write_data),
    .result           (result),
    .result_valid     (result_valid),
    .busy             (busy),
    .misaligned_error (misaligned_error),
    .range_error      (range_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'(i);
  endtask

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int idx;
    int sh;
    logic [31:0] m;
    idx = int'(a[6:2]);
    sh  = 8 * int'(a[1:0]);
    case (sz)
      2'b00:   m = 32'h0000_00FF;
      2'b01:   m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    mdl[idx] = (mdl[idx] & ~(m << sh)) | ((d & m) << sh);
  endtask

  task automatic req(input logic w, input logic r, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    mem_write     = w;
    mem_read      = r;
    size          = sz;
    unsigned_load = u;
    address       = a;
    write_data    = d;
    @(posedge clock);
    #1;
    mem_write = 1'b0;
    mem_read  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    req(1'b1, 1'b0, sz, 1'b0, a, d);
    model_store(sz, a, d);
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] exp);
    req(1'b0, 1'b1, sz, u, a, 32'h0);
    check(tag, result, exp);
    check({tag, "_vld"}, {31'b0, result_valid}, 32'd1);
  endtask

  // Counts rising edges until busy drops; optionally pokes a store while busy
  task automatic count_busy(input bit poke, output int n);
    n = 0;
    if (poke) begin
      mem_write  = 1'b1;
      size       = 2'b10;
      address    = 32'h0;
      write_data = 32'hFFFF_FFFF;
    end
    while (busy && n < 200) begin
      @(posedge clock);
      #1;
      n++;
      if (poke && n <= 3) begin
        check("busy_req_vld", {31'b0, result_valid}, 32'd0);
        check("busy_req_mis", {31'b0, misaligned_error}, 32'd0);
        check("busy_req_rng", {31'b0, range_error}, 32'd0);
      end
      if (n == 3) mem_write = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total       = 0;
    n_bad         = 0;
    reset         = 1'b1;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    size          = 2'b00;
    unsigned_load = 1'b0;
    address       = 32'h0;
    write_data    = 32'h0;
    model_init();

    // Reset state
    #12;
    check("rst_result", result, 32'h0);
    check("rst_vld", {31'b0, result_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_mis", {31'b0, misaligned_error}, 32'd0);
    check("rst_rng", {31'b0, range_error}, 32'd0);

    // Preload takes exactly DEPTH cycles
    @(negedge clock);
    reset = 1'b0;
    count_busy(1'b0, n_busy);
    check("busy_len", 32'(n_busy), 32'd32);

    load("lw_14", 2'b10, 1'b0, 32'h14, 32'h0000_0005);
    idle();
    check("lw_14_vld_drop", {31'b0, result_valid}, 32'd0);
    check("lw_14_hold", result, 32'h0000_0005);

    // Byte store and sign/zero-extended byte loads
    store(2'b00, 32'h09, 32'hAB12_CD80);
    check("sb_vld", {31'b0, result_valid}, 32'd0);
    load("lb_09", 2'b00, 1'b0, 32'h09, 32'hFFFF_FF80);
    load("lbu_09", 2'b00, 1'b1, 32'h09, 32'h0000_0080);
    load("lw_08", 2'b10, 1'b0, 32'h08, 32'h0000_8002);

    // Upper-half store and half loads
    store(2'b01, 32'h0E, 32'h0000_BEEF);
    load("lh_0e", 2'b01, 1'b0, 32'h0E, 32'hFFFF_BEEF);
    load("lhu_0e", 2'b01, 1'b1, 32'h0E, 32'h0000_BEEF);
    load("lw_0c", 2'b10, 1'b0, 32'h0C, 32'hBEEF_0003);

    // Misaligned half: pulse, no result update
    req(1'b0, 1'b1, 2'b01, 1'b0, 32'h03, 32'h0);
    check("lh_03_mis", {31'b0, misaligned_error}, 32'd1);
    check("lh_03_rng", {31'b0, range_error}, 32'd0);
    check("lh_03_vld", {31'b0, result_valid}, 32'd0);
    check("lh_03_hold", result, 32'hBEEF_0003);
    idle();
    check("lh_03_mis_drop", {31'b0, misaligned_error}, 32'd0);

    // Reserved size is always an alignment error
    req(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h0);
    check("rsvd_mis", {31'b0, misaligned_error}, 32'd1);
    check("rsvd_vld", {31'b0, result_valid}, 32'd0);

    // Out-of-range store touches nothing
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'hDEAD_BEEF);
    check("sw_80_rng", {31'b0, range_error}, 32'd1);
    check("sw_80_mis", {31'b0, misaligned_error}, 32'd0);
    idle();
    check("sw_80_rng_drop", {31'b0, range_error}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      load($sformatf("dump%0d", i), 2'b10, 1'b0, 32'(i * 4), mdl[i]);
    end

    // Both errors at once
    req(1'b0, 1'b1, 2'b10, 1'b0, 32'h82, 32'h0);
    check("lw_82_rng", {31'b0, range_error}, 32'd1);
    check("lw_82_mis", {31'b0, misaligned_error}, 32'd1);
    check("lw_82_vld", {31'b0, result_valid}, 32'd0);

    // Last valid word and positive byte sign extension
    load("lw_7c", 2'b10, 1'b0, 32'h7C, 32'h0000_001F);
    load("lb_7c", 2'b00, 1'b0, 32'h7C, 32'h0000_001F);

    // Write and read together: write wins, no response
    req(1'b1, 1'b1, 2'b10, 1'b0, 32'h04, 32'h1234_5678);
    model_store(2'b10, 32'h04, 32'h1234_5678);
    check("wr_rd_vld", {31'b0, result_valid}, 32'd0);
    check("wr_rd_hold", result, 32'h0000_001F);
    load("lw_04", 2'b10, 1'b0, 32'h04, 32'h1234_5678);

    // Reset mid-preload restarts the full sequence; busy-time store ignored
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("rst2_busy", {31'b0, busy}, 32'd1);
    check("rst2_result", result, 32'h0);
    model_init();
    @(negedge clock);
    reset = 1'b0;
    count_busy(1'b1, n_busy);
    check("busy_len2", 32'(n_busy), 32'd32);
    load("lw_00_after", 2'b10, 1'b0, 32'h00, 32'h0000_0000);
    load("lw_04_after", 2'b10, 1'b0, 32'h04, 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
